// File: rtl/pe_conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for the convolution window buffer.
// Both channels transfer when valid && ready are high at a posedge; a producer holds valid and its payload until then.
interface pe_conv_window_buffer_if #(
   parameter int pIN_CHANNEL  = 1,
   parameter int pDATA_WIDTH  = 8,
   parameter int pIMG_WIDTH   = 28,
   parameter int pIMG_HEIGHT  = 28,
   parameter int pKERNEL_SIZE = 3
) ();
   localparam int CW  = pIN_CHANNEL * pDATA_WIDTH;
   localparam int WW  = pKERNEL_SIZE * pKERNEL_SIZE * CW;
   localparam int RW  = $clog2(pIMG_HEIGHT);
   localparam int CLW = $clog2(pIMG_WIDTH);

   logic           in_valid;
   logic           in_ready;
   logic [CW-1:0]  in_data;
   logic           window_valid;
   logic           window_ready;
   logic [WW-1:0]  window;
   logic [RW-1:0]  out_row;
   logic [CLW-1:0] out_col;
   logic           frame_done;

   modport master (
      output in_valid, in_data, window_ready,
      input  in_ready, window_valid, window, out_row, out_col, frame_done
   );

   modport slave (
      input  in_valid, in_data, window_ready,
      output in_ready, window_valid, window, out_row, out_col, frame_done
   );
endinterface

// File: rtl/pe_conv_window_buffer.sv
// Raster-order line buffer and KxK sliding-window generator (stride 1, no padding)
// feeding the convolution PE; a presented window is held until the PE accepts it.
module pe_conv_window_buffer #(
   parameter int pIN_CHANNEL  = 1,
   parameter int pDATA_WIDTH  = 8,
   parameter int pIMG_WIDTH   = 28,
   parameter int pIMG_HEIGHT  = 28,
   parameter int pKERNEL_SIZE = 3
) (
   input logic clk,
   input logic rst,
   pe_conv_window_buffer_if.slave bus
);
   localparam int K   = pKERNEL_SIZE;
   localparam int CW  = pIN_CHANNEL * pDATA_WIDTH;
   localparam int WW  = K * K * CW;
   localparam int RW  = $clog2(pIMG_HEIGHT);
   localparam int CLW = $clog2(pIMG_WIDTH);

   localparam logic [RW-1:0]  ROW_LAST = RW'(pIMG_HEIGHT - 1);
   localparam logic [CLW-1:0] COL_LAST = CLW'(pIMG_WIDTH - 1);
   localparam logic [RW-1:0]  ROW_K    = RW'(K - 1);
   localparam logic [CLW-1:0] COL_K    = CLW'(K - 1);

   logic [RW-1:0]  row_r;
   logic [CLW-1:0] col_r;
   logic           window_valid_r;
   logic [RW-1:0]  out_row_r;
   logic [CLW-1:0] out_col_r;
   logic           frame_done_r;
   logic           in_fire;
   logic           win_fire;

   logic [CW-1:0]  win_r  [K][K];
   logic [CW-1:0]  lb     [K-1][pIMG_WIDTH];
   logic [CW-1:0]  lb_out [K-1];
   logic [WW-1:0]  window_flat;

   // The only stall source is an unaccepted window occupying the output.
   assign bus.in_ready = !window_valid_r || bus.window_ready;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign win_fire     = window_valid_r && bus.window_ready;

   assign bus.window_valid = window_valid_r;
   assign bus.window       = window_flat;
   assign bus.out_row      = out_row_r;
   assign bus.out_col      = out_col_r;
   assign bus.frame_done   = frame_done_r;

   always_comb begin
      for (int i = 0; i < K - 1; i++) begin
         lb_out[i] = lb[i][col_r];
      end
   end

   // Cascaded row delays: buffer i returns the pixel i+1 rows above the current one.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         lb[0][col_r] <= bus.in_data;
         for (int i = 1; i < K - 1; i++) begin
            lb[i][col_r] <= lb_out[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_r[r][c] <= '0;
            end
         end
      end else if (in_fire) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_r[r][c] <= win_r[r][c+1];
            end
         end
         for (int r = 0; r < K - 1; r++) begin
            win_r[r][K-1] <= lb_out[K-2-r];
         end
         win_r[K-1][K-1] <= bus.in_data;
      end
   end

   always_comb begin
      window_flat = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            window_flat[(r*K+c)*CW +: CW] = win_r[r][c];
         end
      end
   end

   // The column gate also rejects windows that would wrap across a row boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_r          <= '0;
         col_r          <= '0;
         window_valid_r <= 1'b0;
         out_row_r      <= '0;
         out_col_r      <= '0;
         frame_done_r   <= 1'b0;
      end else begin
         frame_done_r <= in_fire && (row_r == ROW_LAST) && (col_r == COL_LAST);
         if (in_fire) begin
            if (col_r == COL_LAST) begin
               col_r <= '0;
               row_r <= (row_r == ROW_LAST) ? '0 : row_r + RW'(1);
            end else begin
               col_r <= col_r + CLW'(1);
            end
            window_valid_r <= (row_r >= ROW_K) && (col_r >= COL_K);
            out_row_r      <= row_r - ROW_K;
            out_col_r      <= col_r - COL_K;
         end else if (win_fire) begin
            window_valid_r <= 1'b0;
         end
      end
   end
endmodule
